// File: rtl/clk_cfg_seq.sv
// Configuration sequencer for the I2S clock divider: accepts a new OP over req/ack,
// drains the current frame, holds clk_div in reset while OP changes, then waits for sclk.
package clk_cfg_pkg;
  typedef enum logic [1:0] {MT, MR, ST, SR} mode_t;
  typedef enum logic [1:0] {k8, k16, k32, k64} sys_freq_t;
  typedef enum logic [1:0] {hz32, hz44, hz48, hz96} fs_t;
  typedef enum logic {stereo, mono} chan_t;
  typedef enum logic [1:0] {f16bits, f24bits, f32bits, f8bits} fmt_t;

  typedef struct packed {
    mode_t     mode;
    logic      mclk_en;
    sys_freq_t sys_freq;
    fs_t       fs;
    chan_t     chan;
    fmt_t      fmt;
  } OP_t;
endpackage

module clk_cfg_seq
  import clk_cfg_pkg::*;
#(
  parameter int HOLD_CYC     = 4,
  parameter int SETTLE_EDGES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int DRAIN_MAX    = 4096
) (
  input  logic pclk,
  input  logic rst,
  input  logic cfg_req,
  input  OP_t  cfg_in,
  input  logic cfg_stop,
  input  logic sclk,
  input  logic ws,
  output OP_t  op_out,
  output logic div_rst_,
  output logic clk_ready,
  output logic cfg_ack,
  output logic cfg_busy,
  output logic cfg_err
);

  // One shared cycle timer sized for the longest wait; it is cleared on every state entry.
  localparam int T1   = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT;
  localparam int TMAX = (T1 > DRAIN_MAX) ? T1 : DRAIN_MAX;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int EW   = $clog2(SETTLE_EDGES + 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, HOLD, SETTLE, ERR} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [EW-1:0] edge_reg;
  logic          stop_reg, stop_next;
  OP_t           pend_reg;
  logic          ack_reg;
  logic          accept;
  logic [1:0]    sclk_sync_reg, ws_sync_reg;
  logic          sclk_prev_reg, ws_prev_reg;
  logic          sclk_rise, ws_edge, edge_done;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
  assign ws_edge   = ws_sync_reg[1] ^ ws_prev_reg;
  assign edge_done = sclk_rise && (edge_reg == EW'(SETTLE_EDGES - 1));
  assign cfg_ack   = ack_reg;

  always_comb begin
    state_next = state_reg;
    stop_next  = stop_reg;
    accept     = 1'b0;
    clk_ready  = 1'b0;
    div_rst_   = 1'b0;
    cfg_busy   = 1'b0;
    cfg_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!cfg_stop && cfg_req) begin
          accept     = 1'b1;
          state_next = HOLD;
        end
      end
      RUN: begin
        clk_ready = 1'b1;
        div_rst_  = 1'b1;
        if (cfg_stop) begin
          state_next = DRAIN;
          stop_next  = 1'b1;
        end else if (cfg_req) begin
          accept     = 1'b1;
          state_next = DRAIN;
          stop_next  = 1'b0;
        end
      end
      DRAIN: begin
        cfg_busy = 1'b1;
        div_rst_ = 1'b1;
        if (ws_edge || cnt_reg == CW'(DRAIN_MAX - 1))
          state_next = stop_reg ? IDLE : HOLD;
      end
      HOLD: begin
        cfg_busy = 1'b1;
        if (cnt_reg == CW'(HOLD_CYC - 1))
          state_next = SETTLE;
      end
      SETTLE: begin
        cfg_busy = 1'b1;
        div_rst_ = 1'b1;
        // Edge completion is checked before the timeout so a last-cycle edge still wins.
        if (cfg_stop)
          state_next = IDLE;
        else if (edge_done)
          state_next = RUN;
        else if (cnt_reg == CW'(TIMEOUT - 1))
          state_next = ERR;
      end
      ERR: begin
        cfg_err = 1'b1;
        if (cfg_stop) begin
          state_next = IDLE;
        end else if (cfg_req) begin
          accept     = 1'b1;
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      edge_reg      <= '0;
      stop_reg      <= 1'b0;
      pend_reg      <= '0;
      op_out        <= '0;
      ack_reg       <= 1'b0;
      sclk_sync_reg <= '0;
      ws_sync_reg   <= '0;
      sclk_prev_reg <= 1'b0;
      ws_prev_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stop_reg      <= stop_next;
      ack_reg       <= accept;
      sclk_sync_reg <= {sclk_sync_reg[0], sclk};
      ws_sync_reg   <= {ws_sync_reg[0], ws};
      sclk_prev_reg <= sclk_sync_reg[1];
      ws_prev_reg   <= ws_sync_reg[1];
      if (accept)
        pend_reg <= cfg_in;
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (cnt_reg != '1)
        cnt_reg <= cnt_reg + 1'b1;
      if (state_next != state_reg)
        edge_reg <= '0;
      else if (sclk_rise && edge_reg != '1)
        edge_reg <= edge_reg + 1'b1;
      // OP only changes on the first HOLD cycle, while clk_div is held in reset.
      if (state_reg == HOLD && cnt_reg == '0)
        op_out <= pend_reg;
    end
  end

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Directed bench for clk_cfg_seq: accepted configurations are queued when requested
// and popped when op_out updates at HOLD entry.
module tb_clk_cfg_seq;
  import clk_cfg_pkg::*;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic cfg_req = 1'b0;
  logic cfg_stop = 1'b0;
  OP_t  cfg_in = '0;
  logic sclk = 1'b0;
  logic ws = 1'b0;
  OP_t  op_out;
  logic div_rst_, clk_ready, cfg_ack, cfg_busy, cfg_err;

  logic sclk_en = 1'b0;
  logic ws_en = 1'b0;
  int   ws_div = 0;
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  OP_t  exp_q[$];

  clk_cfg_seq dut (
    .pclk(pclk), .rst(rst), .cfg_req(cfg_req), .cfg_in(cfg_in), .cfg_stop(cfg_stop),
    .sclk(sclk), .ws(ws), .op_out(op_out), .div_rst_(div_rst_), .clk_ready(clk_ready),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  always #5 pclk = ~pclk;

  // sclk edges land at 2 mod 10 ns, never on a pclk edge
  initial begin
    #2;
    forever begin
      #20;
      if (sclk_en) sclk = ~sclk;
      else sclk = 1'b0;
    end
  end

  always @(negedge sclk) begin
    if (ws_en) begin
      if (ws_div == 7) begin
        ws_div = 0;
        ws = ~ws;
      end else begin
        ws_div++;
      end
    end
  end

  always @(negedge pclk) if (cfg_ack === 1'b1) ack_cnt++;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_op(input string tag);
    OP_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected <nothing queued>", tag, op_out);
    end else begin
      e = exp_q.pop_front();
      $display("txn %s: op_out=%0h expected=%0h", tag, op_out, e);
      chk(tag, 32'(op_out), 32'(e));
    end
  endtask

  task automatic send(input OP_t op);
    cfg_in  = op;
    cfg_req = 1'b1;
    exp_q.push_back(op);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (clk_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(clk_ready), 32'(1));
  endtask

  initial begin
    OP_t op1, op2, op3, op4, op5, op6;
    int  a0;
    int  n;
    op1 = '{mode: MT, mclk_en: 1'b1, sys_freq: k32, fs: hz44, chan: stereo, fmt: f16bits};
    op2 = '{mode: MT, mclk_en: 1'b0, sys_freq: k8,  fs: hz48, chan: stereo, fmt: f32bits};
    op3 = '{mode: MR, mclk_en: 1'b1, sys_freq: k16, fs: hz96, chan: mono,   fmt: f24bits};
    op4 = '{mode: ST, mclk_en: 1'b1, sys_freq: k64, fs: hz32, chan: stereo, fmt: f16bits};
    op5 = '{mode: MT, mclk_en: 1'b1, sys_freq: k32, fs: hz44, chan: mono,   fmt: f32bits};
    op6 = '{mode: SR, mclk_en: 1'b0, sys_freq: k16, fs: hz48, chan: stereo, fmt: f24bits};

    ticks(3);
    chk("rst_op_out", 32'(op_out), 32'(0));
    chk("rst_div_rst", 32'(div_rst_), 32'(0));
    chk("rst_clk_ready", 32'(clk_ready), 32'(0));
    chk("rst_ack", 32'(cfg_ack), 32'(0));
    chk("rst_busy", 32'(cfg_busy), 32'(0));
    chk("rst_err", 32'(cfg_err), 32'(0));
    rst = 1'b0;
    sclk_en = 1'b1;
    ws_en = 1'b1;
    ticks(2);
    chk("idle_ready", 32'(clk_ready), 32'(0));

    // First configuration from IDLE
    a0 = ack_cnt;
    send(op1);
    tick();
    chk("t1_ack", 32'(cfg_ack), 32'(1));
    chk("t1_hold_rst", 32'(div_rst_), 32'(0));
    chk("t1_busy", 32'(cfg_busy), 32'(1));
    chk("t1_op_before", 32'(op_out), 32'(0));
    cfg_req = 1'b0;
    tick();
    chk_op("t1_op");
    chk("t1_ack_pulse", 32'(cfg_ack), 32'(0));
    ticks(2);
    chk("t1_hold_last", 32'(div_rst_), 32'(0));
    tick();
    chk("t1_settle_rst", 32'(div_rst_), 32'(1));
    chk("t1_not_ready", 32'(clk_ready), 32'(0));
    wait_ready("t1_ready");
    chk("t1_one_ack", 32'(ack_cnt - a0), 32'(1));
    chk("t1_busy_clr", 32'(cfg_busy), 32'(0));

    // Reconfigure from RUN; drain ends at a ws edge
    a0 = ack_cnt;
    send(op2);
    tick();
    chk("t2_ack", 32'(cfg_ack), 32'(1));
    chk("t2_ready_drop", 32'(clk_ready), 32'(0));
    chk("t2_clk_run", 32'(div_rst_), 32'(1));
    chk("t2_busy", 32'(cfg_busy), 32'(1));
    cfg_req = 1'b0;
    n = 0;
    while (div_rst_ === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("t2_drain_exit", 32'(div_rst_), 32'(0));
    chk("t2_op_held", 32'(op_out), 32'(op1));
    tick();
    chk_op("t2_op");
    wait_ready("t2_ready");
    chk("t2_op_run", 32'(op_out), 32'(op2));
    chk("t2_one_ack", 32'(ack_cnt - a0), 32'(1));

    // ws frozen: DRAIN must time out after exactly DRAIN_MAX cycles
    ws_en = 1'b0;
    ticks(20);
    send(op3);
    tick();
    chk("t3_ack", 32'(cfg_ack), 32'(1));
    cfg_req = 1'b0;
    ticks(4095);
    chk("t3_still_drain", 32'(div_rst_), 32'(1));
    chk("t3_still_busy", 32'(cfg_busy), 32'(1));
    tick();
    chk("t3_hold", 32'(div_rst_), 32'(0));
    tick();
    chk_op("t3_op");
    ws_en = 1'b1;
    wait_ready("t3_ready");

    // Stop together with req: no ack, drain to IDLE; held req acked only in IDLE
    a0 = ack_cnt;
    cfg_in = op4;
    cfg_req = 1'b1;
    cfg_stop = 1'b1;
    tick();
    chk("t5_no_ack", 32'(cfg_ack), 32'(0));
    chk("t5_ready_drop", 32'(clk_ready), 32'(0));
    chk("t5_busy", 32'(cfg_busy), 32'(1));
    chk("t5_clk_run", 32'(div_rst_), 32'(1));
    cfg_stop = 1'b0;
    n = 0;
    while (cfg_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("t5_idle_busy", 32'(cfg_busy), 32'(0));
    chk("t5_idle_rst", 32'(div_rst_), 32'(0));
    chk("t5_idle_ready", 32'(clk_ready), 32'(0));
    chk("t5_no_ack_busy", 32'(ack_cnt - a0), 32'(0));
    exp_q.push_back(op4);
    sclk_en = 1'b0;
    tick();
    chk("t5_ack_idle", 32'(cfg_ack), 32'(1));
    chk("t4_hold_rst", 32'(div_rst_), 32'(0));
    cfg_req = 1'b0;
    tick();
    chk_op("t4_op");

    // sclk dead: ERR exactly at SETTLE cycle TIMEOUT
    ticks(1026);
    chk("t4_pre_err", 32'(cfg_err), 32'(0));
    chk("t4_settle_rst", 32'(div_rst_), 32'(1));
    tick();
    chk("t4_err", 32'(cfg_err), 32'(1));
    chk("t4_err_rst", 32'(div_rst_), 32'(0));
    chk("t4_err_ready", 32'(clk_ready), 32'(0));
    chk("t4_err_busy", 32'(cfg_busy), 32'(0));

    sclk_en = 1'b1;
    a0 = ack_cnt;
    send(op5);
    tick();
    chk("t4b_ack", 32'(cfg_ack), 32'(1));
    chk("t4b_err_clr", 32'(cfg_err), 32'(0));
    cfg_req = 1'b0;
    tick();
    chk_op("t4b_op");
    wait_ready("t4b_ready");
    chk("t4b_one_ack", 32'(ack_cnt - a0), 32'(1));

    // Reset during SETTLE
    a0 = ack_cnt;
    send(op6);
    tick();
    cfg_req = 1'b0;
    n = 0;
    while (div_rst_ === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("t6_hold", 32'(div_rst_), 32'(0));
    tick();
    chk_op("t6_op");
    n = 0;
    while (div_rst_ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_settle", 32'(div_rst_), 32'(1));
    chk("t6_settle_busy", 32'(cfg_busy), 32'(1));
    rst = 1'b1;
    tick();
    chk("t6_op_out", 32'(op_out), 32'(0));
    chk("t6_div_rst", 32'(div_rst_), 32'(0));
    chk("t6_clk_ready", 32'(clk_ready), 32'(0));
    chk("t6_ack", 32'(cfg_ack), 32'(0));
    chk("t6_busy", 32'(cfg_busy), 32'(0));
    chk("t6_err", 32'(cfg_err), 32'(0));
    rst = 1'b0;
    ticks(10);
    chk("t6_no_late_ack", 32'(ack_cnt - a0), 32'(1));
    chk("t6_idle_ready", 32'(clk_ready), 32'(0));
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
